mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage pipeline. Holds the EX/MEM pipeline register and drives the data-cache request. It waits on `dhit` with a small request FSM and raises `mem_busy` to the hazard unit. It presents word-wide results (ALU output, loaded data, write-back controls) to the MEM/WB latch directly downstream.

## Interface

Parameters
- `WORD_W`, 32, data/address width (`word_t`).
- `REG_W`, 5, register-select width (`regbits_t`).

Ports (`name  direction  width  meaning`)
- `CLK`  in  1  pipeline clock, rising edge.
- `RST`  in  1  **asynchronous, active-high** reset.
- `en`  in  1  pipeline advance from the hazard unit.
- `flush`  in  1  synchronous bubble insert (sRST equivalent).
- `porto_in`  in  32  ALU result / effective address.
- `store_in`  in  32  rt data for stores.
- `wsel_in`  in  5  destination register.
- `regen_in`  in  1  register write enable.
- `regsrc_in`  in  2  write-back source select; passed through unchanged.
- `dren_in`, `dwen_in`  in  1 each  load op / store op.
- `halt_in`  in  1  halt marker.
- `dhit`  in  1  cache completed current access.
- `dload`  in  32  cache read data.
- `dmemren`, `dmemwen`  out  1 each  cache request.
- `dmemaddr`, `dmemstore`  out  32 each  request address / write data.
- `mem_busy`  out  1  stall request to the hazard unit.
- `porto`, `dmemload`  out  32 each  to MEM/WB.
- `wsel`  out  5  to MEM/WB.
- `regen`  out  1  to MEM/WB.
- `regsrc`  out  2  to MEM/WB.
- `halt`  out  1  to MEM/WB.

## Operation

- Latch update occurs when `en & ~mem_busy`.
  - If `flush` is also high, load a bubble: all controls 0, data fields 0.
  - Otherwise load all `*_in` fields.
- `flush` while `mem_busy` is ignored. The hazard unit never flushes MEM during an access.
- FSM states and transitions:
  - IDLE
    - Latch update with `dren_in|dwen_in` → REQ.
    - Otherwise stays in IDLE.
  - REQ
    - `dmemren`/`dmemwen` follow the latched op; `dmemaddr = porto`; `dmemstore = store`.
    - `dhit & en`: latch update; next state is REQ if the new op is a memory op, else IDLE.
    - `dhit & ~en`: capture `dload` into the data register → DONE.
    - `~dhit`: stay in REQ.
  - DONE
    - Request lines are 0, so the cache sees no duplicate access.
    - `en` → latch update; next state as from IDLE.
- Output and stall rules:
  - `mem_busy = (state==REQ) & ~dhit`.
  - `dmemload = (state==REQ) ? dload : data_reg`.
  - Both `dren` and `dwen` set at once is illegal; load wins.
- Reset: state IDLE, all register fields 0, so every output is 0.

## Timing

- Request lines assert in the cycle after the op is latched.
- Hit in the first REQ cycle: zero stall cycles; MEM/WB captures `dload` on that edge.
- Each miss cycle adds one `mem_busy` cycle.
- `dhit` arriving in IDLE or DONE is ignored.
- `RST` during REQ: the request drops immediately (asynchronously).

## Configuration

- `LLSC_EN` compiles in load-linked/store-conditional support.
- Added ports with the macro:
  - `datomic_in` (1): marks LL/SC.
  - `ccinv` (1) and `ccsnoopaddr` (32): invalidations from the coherence controller.
- Link state: `linkaddr`/`linkvalid` registers.
- LL: on hit, set `linkaddr = porto` and `linkvalid = 1`.
- SC, link matches:
  - Issues the write.
  - On hit, `porto` is overridden to 1.
  - Clears `linkvalid`.
- SC, link mismatch:
  - No write is issued.
  - Goes IDLE→DONE-equivalent with `porto = 0` and no busy cycle.
- Link clearing: a plain store hit to `linkaddr`, or `ccinv` with `ccsnoopaddr == linkaddr`, clears `linkvalid`.
- Without the macro:
  - These ports are absent.
  - Atomics are treated as plain loads/stores.

## Structure

- `cpu_types_pkg` gains:
  - `memstate_t` enum (`IDLE`, `REQ`, `DONE`).
  - `regsrc` encoding constants.
- `word_t` and `regbits_t` come from the existing package.
- One sub-module, `dmem_req_fsm`: state register, request lines, `mem_busy`, data capture.
- The pipeline register stays in `mem_stage`.

## Test plan

- Reset mid-REQ → all outputs 0 asynchronously, state IDLE.
- Load addr 0x100, `dhit` in first REQ cycle with `dload=0xDEADBEEF`, `en=1` → no busy; `dmemload=0xDEADBEEF` at MEM/WB edge.
- Store 0x55 to 0x200 with `dhit` 3 cycles late → `mem_busy` high exactly 3 cycles; `dmemwen` drops after hit.
- Load hit with `en=0` for 2 cycles → DONE; `dmemren=0`; `dmemload` holds value; advances on `en`.
- `flush` during REQ ignored; `flush` with `en` in IDLE → `regen=0`, `wsel=0`.
- `LLSC_EN`: LL 0x300, then `ccinv` for 0x300, then SC 0x300 → no `dmemwen`, `porto=0`. Repeat without `ccinv` → write issued, `porto=1`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU pipeline types
// Contents:
//   word_t / regbits_t : datapath word and register-select types
//   memstate_t         : data-cache request FSM states (IDLE, REQ, DONE)
//   REGSRC_*           : write-back source select encodings
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;
  localparam int CPU_REG_W  = 5;

  typedef logic [CPU_WORD_W-1:0] word_t;
  typedef logic [CPU_REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memstate_t;

  localparam logic [1:0] REGSRC_ALU = 2'd0;
  localparam logic [1:0] REGSRC_MEM = 2'd1;
  localparam logic [1:0] REGSRC_PC  = 2'd2;
  localparam logic [1:0] REGSRC_IMM = 2'd3;

endpackage

// File: rtl/dmem_req_fsm.sv
// rtl/dmem_req_fsm.sv - data-cache request FSM for the memory stage
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   en            : pipeline advance from the hazard unit
//   hit           : current access completed
//   next_mem_op   : the op entering the EX/MEM latch is a load or store
//   op_ren/op_wen : latched op kind (already resolved so at most one is set)
//   dload         : cache read data
//   dmemren/wen   : cache request lines, only driven in REQ
//   mem_busy      : stall request (REQ without hit)
//   upd           : EX/MEM latch update strobe
//   req_active    : FSM is in REQ
//   dmemload      : load data toward MEM/WB
module dmem_req_fsm
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              hit,
  input  logic              next_mem_op,
  input  logic              op_ren,
  input  logic              op_wen,
  input  logic [WORD_W-1:0] dload,
  output logic              dmemren,
  output logic              dmemwen,
  output logic              mem_busy,
  output logic              upd,
  output logic              req_active,
  output logic [WORD_W-1:0] dmemload
);

  memstate_t         state_q, state_d;
  logic [WORD_W-1:0] data_q;

  assign req_active = (state_q == REQ);
  assign mem_busy   = req_active & ~hit;
  assign upd        = en & ~mem_busy;
  // In REQ the cache data goes straight through so a first-cycle hit costs nothing.
  assign dmemload   = req_active ? dload : data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      // Hit while the pipeline is held: park the data until MEM/WB takes it.
      if (req_active && hit && !en) begin
        data_q <= dload;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dmemren = 1'b0;
    dmemwen = 1'b0;
    case (state_q)
      IDLE: begin
        if (upd && next_mem_op) state_d = REQ;
      end
      REQ: begin
        dmemren = op_ren;
        dmemwen = op_wen;
        if (hit) begin
          if (en) state_d = next_mem_op ? REQ : IDLE;
          else    state_d = DONE;
        end
      end
      DONE: begin
        if (en) state_d = next_mem_op ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: EX/MEM register and data-cache request
// Optional feature macro: LLSC_EN (load-linked / store-conditional).
// Ports:
//   CLK, RST                : clock, asynchronous active-high reset
//   en, flush               : advance / bubble insert from the hazard unit
//   *_in                    : EX stage results and controls
//   datomic_in, ccinv,
//   ccsnoopaddr             : LL/SC marker and coherence invalidation (LLSC_EN only)
//   dhit, dload             : cache response
//   dmemren/wen/addr/store  : cache request
//   mem_busy                : stall request to the hazard unit
//   porto, dmemload, wsel,
//   regen, regsrc, halt     : results to MEM/WB
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              flush,
  input  logic [WORD_W-1:0] porto_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic [REG_W-1:0]  wsel_in,
  input  logic              regen_in,
  input  logic [1:0]        regsrc_in,
  input  logic              dren_in,
  input  logic              dwen_in,
  input  logic              halt_in,
`ifdef LLSC_EN
  input  logic              datomic_in,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
`endif
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  output logic              dmemren,
  output logic              dmemwen,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_busy,
  output logic [WORD_W-1:0] porto,
  output logic [WORD_W-1:0] dmemload,
  output logic [REG_W-1:0]  wsel,
  output logic              regen,
  output logic [1:0]        regsrc,
  output logic              halt
);

  logic [WORD_W-1:0] porto_r, store_r;
  logic [REG_W-1:0]  wsel_r;
  logic [1:0]        regsrc_r;
  logic              regen_r, dren_r, dwen_r, halt_r;

  logic upd, req_active, next_mem_op;
  logic op_ren, op_wen, fsm_hit, fsm_wen;

  // A flushed op becomes a bubble, so it must not start an access.
  assign next_mem_op = ~flush & (dren_in | dwen_in);
  // Load and store together is illegal; the load is kept.
  assign op_ren = dren_r;
  assign op_wen = dwen_r & ~dren_r;

`ifdef LLSC_EN
  logic              datomic_r;
  logic [WORD_W-1:0] link_addr;
  logic              link_valid;
  logic              ll_op, sc_op, sc_ok, sc_fail, sc_resolve, link_kill;

  assign ll_op   = datomic_r & dren_r;
  assign sc_op   = datomic_r & op_wen;
  assign sc_ok   = link_valid & (link_addr == porto_r);
  // A failing SC never reaches the cache: it completes as if it hit, with no busy cycle.
  assign sc_fail    = req_active & sc_op & ~sc_ok;
  assign fsm_hit    = dhit | sc_fail;
  assign fsm_wen    = op_wen & ~sc_fail;
  assign sc_resolve = req_active & sc_op & fsm_hit;
  assign link_kill  = sc_resolve
                    | (req_active & dhit & op_wen & ~datomic_r & (porto_r == link_addr))
                    | (ccinv & (ccsnoopaddr == link_addr));
  assign porto      = (req_active & sc_op) ? {{(WORD_W-1){1'b0}}, sc_ok} : porto_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_addr  <= '0;
      link_valid <= 1'b0;
    end else if (req_active && dhit && ll_op) begin
      link_addr  <= porto_r;
      link_valid <= 1'b1;
    end else if (link_kill) begin
      link_valid <= 1'b0;
    end
  end
`else
  assign fsm_hit = dhit;
  assign fsm_wen = op_wen;
  assign porto   = porto_r;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      porto_r  <= '0;
      store_r  <= '0;
      wsel_r   <= '0;
      regen_r  <= 1'b0;
      regsrc_r <= '0;
      dren_r   <= 1'b0;
      dwen_r   <= 1'b0;
      halt_r   <= 1'b0;
`ifdef LLSC_EN
      datomic_r <= 1'b0;
`endif
    end else if (upd) begin
      if (flush) begin
        porto_r  <= '0;
        store_r  <= '0;
        wsel_r   <= '0;
        regen_r  <= 1'b0;
        regsrc_r <= '0;
        dren_r   <= 1'b0;
        dwen_r   <= 1'b0;
        halt_r   <= 1'b0;
`ifdef LLSC_EN
        datomic_r <= 1'b0;
`endif
      end else begin
        porto_r  <= porto_in;
        store_r  <= store_in;
        wsel_r   <= wsel_in;
        regen_r  <= regen_in;
        regsrc_r <= regsrc_in;
        dren_r   <= dren_in;
        dwen_r   <= dwen_in;
        halt_r   <= halt_in;
`ifdef LLSC_EN
        datomic_r <= datomic_in;
`endif
      end
    end
`ifdef LLSC_EN
    // SC resolved while held: the address is no longer needed, keep the status instead.
    else if (sc_resolve) begin
      porto_r <= {{(WORD_W-1){1'b0}}, sc_ok};
    end
`endif
  end

  dmem_req_fsm #(.WORD_W(WORD_W)) u_fsm (
    .CLK         (CLK),
    .RST         (RST),
    .en          (en),
    .hit         (fsm_hit),
    .next_mem_op (next_mem_op),
    .op_ren      (op_ren),
    .op_wen      (fsm_wen),
    .dload       (dload),
    .dmemren     (dmemren),
    .dmemwen     (dmemwen),
    .mem_busy    (mem_busy),
    .upd         (upd),
    .req_active  (req_active),
    .dmemload    (dmemload)
  );

  // Address and store data are only presented while a request is outstanding.
  assign dmemaddr  = req_active ? porto_r : '0;
  assign dmemstore = req_active ? store_r : '0;
  assign wsel      = wsel_r;
  assign regen     = regen_r;
  assign regsrc    = regsrc_r;
  assign halt      = halt_r;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, en, flush;
  logic [31:0] porto_in, store_in;
  logic [4:0]  wsel_in;
  logic        regen_in, dren_in, dwen_in, halt_in, datomic_in;
  logic [1:0]  regsrc_in;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dhit;
  logic [31:0] dload;
  logic        dmemren, dmemwen, mem_busy, regen, halt;
  logic [31:0] dmemaddr, dmemstore, porto, dmemload;
  logic [4:0]  wsel;
  logic [1:0]  regsrc;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .porto_in(porto_in), .store_in(store_in), .wsel_in(wsel_in),
    .regen_in(regen_in), .regsrc_in(regsrc_in), .dren_in(dren_in),
    .dwen_in(dwen_in), .halt_in(halt_in),
`ifdef LLSC_EN
    .datomic_in(datomic_in), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
`endif
    .dhit(dhit), .dload(dload),
    .dmemren(dmemren), .dmemwen(dmemwen), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_busy(mem_busy), .porto(porto),
    .dmemload(dmemload), .wsel(wsel), .regen(regen), .regsrc(regsrc),
    .halt(halt)
  );

  typedef struct packed {
    logic [31:0] porto;
    logic [31:0] ld;
    logic        ld_chk;
    logic [4:0]  wsel;
    logic        regen;
    logic [1:0]  regsrc;
    logic        halt;
  } rec_t;

  rec_t  q[$];
  rec_t  nxt;
  rec_t  r;
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed=%h expected=%h", cur, tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("dmemren",   32'(dmemren),  32'd0);
    chk("dmemwen",   32'(dmemwen),  32'd0);
    chk("dmemaddr",  dmemaddr,      32'd0);
    chk("dmemstore", dmemstore,     32'd0);
    chk("mem_busy",  32'(mem_busy), 32'd0);
    chk("porto",     porto,         32'd0);
    chk("dmemload",  dmemload,      32'd0);
    chk("wsel",      32'(wsel),     32'd0);
    chk("regen",     32'(regen),    32'd0);
    chk("regsrc",    32'(regsrc),   32'd0);
    chk("halt",      32'(halt),     32'd0);
  endtask

  // Drives one EX-stage op and records what MEM/WB must see when it leaves this stage.
  task automatic set_op(input logic [31:0] a, input logic [31:0] st, input logic [4:0] ws,
                        input logic re, input logic [1:0] rs, input logic ld, input logic sw,
                        input logic hl, input logic at, input logic [31:0] exp_porto,
                        input logic [31:0] exp_ld, input logic ld_chk);
    porto_in = a; store_in = st; wsel_in = ws; regen_in = re; regsrc_in = rs;
    dren_in = ld; dwen_in = sw; halt_in = hl; datomic_in = at;
    nxt.porto = exp_porto; nxt.ld = exp_ld; nxt.ld_chk = ld_chk;
    nxt.wsel = ws; nxt.regen = re; nxt.regsrc = rs; nxt.halt = hl;
  endtask

  task automatic set_nop();
    set_op(32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Called at a falling edge after inputs are set; checks busy and, on an
  // advancing cycle, the MEM/WB capture, then moves to the next falling edge.
  task automatic tick(input logic exp_busy);
    #1;
    chk("mem_busy", 32'(mem_busy), 32'(exp_busy));
    if (en && !exp_busy) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL %s/capture: observed=record expected=none", cur);
      end else begin
        r = q.pop_front();
        chk("wb_porto",  porto,         r.porto);
        chk("wb_wsel",   32'(wsel),     32'(r.wsel));
        chk("wb_regen",  32'(regen),    32'(r.regen));
        chk("wb_regsrc", 32'(regsrc),   32'(r.regsrc));
        chk("wb_halt",   32'(halt),     32'(r.halt));
        if (r.ld_chk) chk("wb_dmemload", dmemload, r.ld);
      end
      q.push_back(nxt);
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0; en = 1'b0; flush = 1'b0; dhit = 1'b0; dload = '0;
    ccinv = 1'b0; ccsnoopaddr = '0;
    set_nop();
    #1 RST = 1'b1;
    #2;
    cur = "reset";
    chk_zero();
    @(negedge CLK);
    RST = 1'b0; en = 1'b1;
    r = '0; r.ld_chk = 1'b1; q.push_back(r);

    cur = "load_hit";
    set_op(32'h100, 0, 5'd3, 1, REGSRC_MEM, 1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 1);
    tick(0);
    dhit = 1; dload = 32'hDEADBEEF; set_nop();
    #1;
    chk("dmemren", 32'(dmemren), 32'd1);
    chk("dmemwen", 32'(dmemwen), 32'd0);
    chk("dmemaddr", dmemaddr, 32'h100);
    tick(0);
    dhit = 0; dload = '0;

    cur = "store_miss3";
    set_op(32'h200, 32'h55, 5'd0, 0, REGSRC_ALU, 0, 1, 0, 0, 32'h200, 0, 0);
    tick(0);
    set_op(32'h1234, 0, 5'd7, 1, REGSRC_ALU, 0, 0, 0, 0, 32'h1234, 0, 0);
    #1;
    chk("dmemwen", 32'(dmemwen), 32'd1);
    chk("dmemren", 32'(dmemren), 32'd0);
    chk("dmemaddr", dmemaddr, 32'h200);
    chk("dmemstore", dmemstore, 32'h55);
    tick(1); tick(1); tick(1);
    dhit = 1;
    tick(0);
    dhit = 0;
    #1;
    chk("dmemwen_after", 32'(dmemwen), 32'd0);

    cur = "load_stall";
    set_op(32'h140, 0, 5'd9, 1, REGSRC_MEM, 1, 0, 0, 0, 32'h140, 32'hCAFEF00D, 1);
    tick(0);
    en = 0; dhit = 1; dload = 32'hCAFEF00D; set_nop();
    #1 chk("dmemren", 32'(dmemren), 32'd1);
    tick(0);
    dhit = 1; dload = 32'h0BADBAD0;
    #1;
    chk("done_ren", 32'(dmemren), 32'd0);
    chk("done_wen", 32'(dmemwen), 32'd0);
    chk("done_load", dmemload, 32'hCAFEF00D);
    tick(0);
    dhit = 0;
    #1 chk("done_hold", dmemload, 32'hCAFEF00D);
    en = 1;
    tick(0);

    cur = "flush";
    set_op(32'h180, 0, 5'd4, 1, REGSRC_MEM, 1, 0, 0, 0, 32'h180, 32'h11112222, 1);
    tick(0);
    flush = 1;
    set_op(32'h77, 0, 5'd12, 1, REGSRC_PC, 0, 0, 0, 0, 32'h77, 0, 0);
    #1 chk("dmemren", 32'(dmemren), 32'd1);
    tick(1);
    flush = 0; dhit = 1; dload = 32'h11112222;
    #1;
    chk("wsel_kept", 32'(wsel), 32'd4);
    chk("dmemaddr", dmemaddr, 32'h180);
    tick(0);
    dhit = 0; flush = 1;
    set_op(32'h2A0, 0, 5'd5, 1, REGSRC_MEM, 1, 0, 0, 0, 0, 0, 0);
    nxt = '0;
    tick(0);
    flush = 0;
    set_op(0, 0, 5'd0, 0, REGSRC_ALU, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("bubble_regen", 32'(regen), 32'd0);
    chk("bubble_wsel", 32'(wsel), 32'd0);
    chk("bubble_ren", 32'(dmemren), 32'd0);
    chk("bubble_porto", porto, 32'd0);
    tick(0);
    set_nop();
    tick(0);

    cur = "back_to_back";
    set_op(32'h400, 0, 5'd1, 1, REGSRC_MEM, 1, 0, 0, 0, 32'h400, 32'hA5A5A5A5, 1);
    tick(0);
    dhit = 1; dload = 32'hA5A5A5A5;
    set_op(32'h404, 32'h99, 5'd0, 0, REGSRC_ALU, 0, 1, 0, 0, 32'h404, 0, 0);
    tick(0);
    dhit = 0; set_nop();
    #1;
    chk("dmemwen", 32'(dmemwen), 32'd1);
    chk("dmemren", 32'(dmemren), 32'd0);
    chk("dmemaddr", dmemaddr, 32'h404);
    chk("dmemstore", dmemstore, 32'h99);
    tick(1);
    dhit = 1;
    tick(0);
    dhit = 0;

    cur = "load_wins";
    set_op(32'h500, 32'h66, 5'd6, 1, REGSRC_MEM, 1, 1, 0, 0, 32'h500, 32'h5, 1);
    tick(0);
    set_nop();
    #1;
    chk("dmemren", 32'(dmemren), 32'd1);
    chk("dmemwen", 32'(dmemwen), 32'd0);
    tick(1);
    dhit = 1; dload = 32'h5;
    tick(0);
    dhit = 0; dload = '0;

    cur = "idle_dhit";
    dhit = 1;
    #1 chk("dmemren", 32'(dmemren), 32'd0);
    tick(0);
    dhit = 0;

`ifdef LLSC_EN
    cur = "llsc_inv";
    set_op(32'h300, 0, 5'd8, 1, REGSRC_MEM, 1, 0, 0, 1, 32'h300, 32'h1, 1);
    tick(0);
    dhit = 1; dload = 32'h1; set_nop();
    tick(0);
    dhit = 0; dload = '0; ccinv = 1; ccsnoopaddr = 32'h300;
    tick(0);
    ccinv = 0;
    set_op(32'h300, 32'hAB, 5'd9, 1, REGSRC_ALU, 0, 1, 0, 1, 32'h0, 0, 0);
    tick(0);
    set_nop();
    #1;
    chk("sc_no_wen", 32'(dmemwen), 32'd0);
    chk("sc_porto0", porto, 32'd0);
    tick(0);

    cur = "llsc_ok";
    set_op(32'h300, 0, 5'd8, 1, REGSRC_MEM, 1, 0, 0, 1, 32'h300, 32'h2, 1);
    tick(0);
    dhit = 1; dload = 32'h2; set_nop();
    tick(0);
    dhit = 0; dload = '0;
    set_op(32'h300, 32'hAB, 5'd9, 1, REGSRC_ALU, 0, 1, 0, 1, 32'h1, 0, 0);
    tick(0);
    set_nop();
    #1;
    chk("sc_wen", 32'(dmemwen), 32'd1);
    chk("sc_store", dmemstore, 32'hAB);
    chk("sc_porto1", porto, 32'd1);
    tick(1);
    dhit = 1;
    tick(0);
    dhit = 0;
`endif

    cur = "reset_req";
    set_op(32'h3C0, 0, 5'd2, 1, REGSRC_MEM, 1, 0, 0, 0, 32'h3C0, 0, 0);
    tick(0);
    set_nop();
    #1 chk("dmemren", 32'(dmemren), 32'd1);
    #2 RST = 1'b1;
    #1 chk_zero();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
